// File: rtl/dsp_mac_sequencer.sv
// Feeds a DSP48A1-style MAC slice from a valid/ready tap stream and returns one dot product per vector.
// Latency: m_valid rises MLAT+2 cycles after the last tap is accepted; a full result holds s_ready low and freezes the slice.
// Optional DSP_SEQ_CNT_EN adds m_taps, the tap count of the vector held in m_result.
module dsp_mac_sequencer #(
  parameter int MLAT = 1,
  parameter int PW   = 48
) (
  input  logic          clk,
  input  logic          RSTN,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [17:0]   s_a,
  input  logic [17:0]   s_b,
  input  logic          s_last,
  output logic [17:0]   dsp_A,
  output logic [17:0]   dsp_B,
  output logic [7:0]    dsp_opmode,
  output logic          dsp_CEM,
  output logic          dsp_CEP,
  output logic          dsp_RST,
  input  logic [PW-1:0] dsp_P,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [PW-1:0] m_result
`ifdef DSP_SEQ_CNT_EN
  ,
  output logic [15:0]   m_taps
`endif
);

  localparam logic [7:0] OPM_HOLD = 8'h08;
  localparam logic [7:0] OPM_LOAD = 8'h01;
  localparam logic [7:0] OPM_ACC  = 8'h09;

  logic          rst_q;
  logic          prev_last_q;
  logic [17:0]   a_q, b_q;
  logic [MLAT+1:0] tag_vld_q;
  logic [MLAT+1:0] tag_last_q;
  logic [MLAT:0]   tag_first_q;
  logic          m_valid_q, m_valid_d;
  logic [PW-1:0] m_result_q;

  logic stall, accept, capture;

  always_comb begin
    stall     = m_valid_q & ~m_ready;
    s_ready   = ~rst_q & ~stall;
    accept    = s_valid & s_ready;
    capture   = ~stall & tag_vld_q[MLAT+1] & tag_last_q[MLAT+1];
    m_valid_d = capture | (m_valid_q & ~m_ready);
  end

  // Slice clock enables follow the stall so M and P freeze with the tag pipeline.
  always_comb begin
    dsp_CEM = ~stall & ~rst_q;
    dsp_CEP = ~stall & ~rst_q;
    dsp_RST = rst_q;
    dsp_A   = a_q;
    dsp_B   = b_q;
    m_valid = m_valid_q;
    m_result = m_result_q;
  end

  always_comb begin
    dsp_opmode = OPM_HOLD;
    if (tag_vld_q[MLAT]) begin
      dsp_opmode = tag_first_q[MLAT] ? OPM_LOAD : OPM_ACC;
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      rst_q       <= 1'b1;
      prev_last_q <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
      tag_first_q <= '0;
      m_valid_q   <= 1'b0;
      m_result_q  <= '0;
    end else begin
      rst_q <= 1'b0;
      if (!stall) begin
        tag_vld_q   <= {tag_vld_q[MLAT:0], accept};
        tag_last_q  <= {tag_last_q[MLAT:0], s_last};
        tag_first_q <= {tag_first_q[MLAT-1:0], prev_last_q};
      end
      if (accept) begin
        a_q         <= s_a;
        b_q         <= s_b;
        prev_last_q <= s_last;
      end
      if (capture) begin
        m_result_q <= dsp_P;
      end
      m_valid_q <= m_valid_d;
    end
  end

`ifdef DSP_SEQ_CNT_EN
  // Each tap carries its running count so a following vector cannot corrupt the captured value.
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tag_cnt_q [MLAT+2];
  logic [15:0] m_taps_q;

  always_comb begin
    if (prev_last_q) begin
      cnt_d = 16'd1;
    end else if (cnt_q == 16'hFFFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    m_taps = m_taps_q;
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q    <= '0;
      m_taps_q <= '0;
      for (int i = 0; i < MLAT + 2; i++) begin
        tag_cnt_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        cnt_q <= cnt_d;
      end
      if (!stall) begin
        tag_cnt_q[0] <= cnt_d;
        for (int i = 1; i < MLAT + 2; i++) begin
          tag_cnt_q[i] <= tag_cnt_q[i-1];
        end
      end
      if (capture) begin
        m_taps_q <= tag_cnt_q[MLAT+1];
      end
    end
  end
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural MREG=1/PREG=1 slice closing the loop on dsp_P.
module tb_dsp_mac_sequencer;

  logic        clk = 1'b0;
  logic        RSTN;
  logic        s_valid, s_ready, s_last;
  logic [17:0] s_a, s_b;
  logic [17:0] dsp_A, dsp_B;
  logic [7:0]  dsp_opmode;
  logic        dsp_CEM, dsp_CEP, dsp_RST;
  logic [47:0] dsp_P;
  logic        m_valid, m_ready;
  logic [47:0] m_result;
`ifdef DSP_SEQ_CNT_EN
  logic [15:0] m_taps;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] res;
    logic [15:0] taps;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.MLAT(1), .PW(48)) dut (
    .clk        (clk),
    .RSTN       (RSTN),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .s_last     (s_last),
    .dsp_A      (dsp_A),
    .dsp_B      (dsp_B),
    .dsp_opmode (dsp_opmode),
    .dsp_CEM    (dsp_CEM),
    .dsp_CEP    (dsp_CEP),
    .dsp_RST    (dsp_RST),
    .dsp_P      (dsp_P),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_result   (m_result)
`ifdef DSP_SEQ_CNT_EN
    ,
    .m_taps     (m_taps)
`endif
  );

  // Slice model: sync reset beats clock enable, X mux picks M on opmode[1:0]=01, Z picks P on opmode[3:2]=10.
  logic signed [47:0] slc_m_q, slc_p_q;
  logic signed [47:0] ext_a, ext_b, slc_x, slc_z;
  always_comb begin
    ext_a = {{30{dsp_A[17]}}, dsp_A};
    ext_b = {{30{dsp_B[17]}}, dsp_B};
    slc_x = (dsp_opmode[1:0] == 2'b01) ? slc_m_q : 48'sd0;
    slc_z = (dsp_opmode[3:2] == 2'b10) ? slc_p_q : 48'sd0;
  end
  always_ff @(posedge clk) begin
    if (dsp_RST) begin
      slc_m_q <= '0;
      slc_p_q <= '0;
    end else begin
      if (dsp_CEM) slc_m_q <= ext_a * ext_b;
      if (dsp_CEP) slc_p_q <= slc_x + slc_z;
    end
  end
  assign dsp_P = slc_p_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [47:0] r, input logic [15:0] t);
    exp_t e;
    e.res  = r;
    e.taps = t;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input logic last);
    int n;
    s_valid = 1'b1;
    s_a     = 18'(a);
    s_b     = 18'(b);
    s_last  = last;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout s_ready=%0b required=1", s_ready);
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!m_valid && k < 50);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: every result handshake pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (RSTN === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h required=none", m_result);
        end else begin
          e = sb_q.pop_front();
          chk("m_result", 64'(m_result), 64'(e.res));
`ifdef DSP_SEQ_CNT_EN
          chk("m_taps", 64'(m_taps), 64'(e.taps));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int k;
    RSTN = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_s_ready", 64'(s_ready), 0);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_m_result", 64'(m_result), 0);
    chk("rst_dsp_A", 64'(dsp_A), 0);
    chk("rst_dsp_B", 64'(dsp_B), 0);
    chk("rst_opmode", 64'(dsp_opmode), 64'h08);
    chk("rst_cem", 64'(dsp_CEM), 0);
    chk("rst_cep", 64'(dsp_CEP), 0);
    chk("rst_dsp_rst", 64'(dsp_RST), 1);
    step();
    RSTN = 1'b1;
    @(negedge clk);
    chk("rel_dsp_rst_hi", 64'(dsp_RST), 1);
    chk("rel_s_ready_lo", 64'(s_ready), 0);
    step();
    chk("rel_dsp_rst_lo", 64'(dsp_RST), 0);
    chk("rel_s_ready_hi", 64'(s_ready), 1);
    chk("rel_opmode", 64'(dsp_opmode), 64'h08);
    chk("rel_m_valid", 64'(m_valid), 0);

    // Two taps back to back: 3*4 + 5*6
    push(48'd42, 16'd2);
    send(3, 4, 1'b0);
    send(5, 6, 1'b1);
    wait_valid(k);
    chk("latency", 64'(k), 3);
    step();
    chk("pulse_once", 64'(m_valid), 0);
    drain();

    // Single negative tap
    push(48'hFFFF_FFFF_FFF2, 16'd1);
    send(-2, 7, 1'b1);
    drain();

    // Vector followed immediately by a single-tap vector
    push(48'd5, 16'd2);
    push(48'd100, 16'd1);
    send(1, 1, 1'b0);
    send(2, 2, 1'b1);
    send(10, 10, 1'b1);
    wait_valid(k);
    chk("b2b_first_valid", 64'(m_valid), 1);
    step();
    chk("b2b_second_valid", 64'(m_valid), 1);
    step();
    chk("b2b_done", 64'(m_valid), 0);
    drain();

    // Stall: result held while a new tap waits
    m_ready = 1'b0;
    push(48'd42, 16'd2);
    send(3, 4, 1'b0);
    send(5, 6, 1'b1);
    wait_valid(k);
    chk("stall_valid", 64'(m_valid), 1);
    s_valid = 1'b1; s_a = 18'd2; s_b = 18'd3; s_last = 1'b1;
    push(48'd6, 16'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_s_ready", 64'(s_ready), 0);
      chk("stall_cem", 64'(dsp_CEM), 0);
      chk("stall_cep", 64'(dsp_CEP), 0);
      chk("stall_m_result", 64'(m_result), 64'd42);
    end
    step();
    m_ready = 1'b1;
    send(2, 3, 1'b1);
    drain();

    // Bubbles between taps, then reset in the middle of the next vector
    push(48'd42, 16'd2);
    send(3, 4, 1'b0);
    step();
    step();
    send(5, 6, 1'b1);
    drain();
    send(7, 7, 1'b0);
    RSTN = 1'b0;
    step();
    chk("midrst_m_valid", 64'(m_valid), 0);
    chk("midrst_s_ready", 64'(s_ready), 0);
    chk("midrst_dsp_rst", 64'(dsp_RST), 1);
    step();
    RSTN = 1'b1;
    push(48'd9, 16'd1);
    send(1, 9, 1'b1);
    drain();
    repeat (5) step();

    chk("sb_empty", 64'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
